// File: rtl/cpu_step_ctrl_pkg.sv
// Shared state encoding and debug-LED decode for the instruction-cycle sequencer.
package cpu_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_BRK  = 2'd3
  } state_e;

  // Debug LED group: {Halted, Bp_hit, State[1:0]}
  typedef struct packed {
    logic       halted;
    logic       bp_hit;
    logic [1:0] state;
  } dbg_t;

  function automatic dbg_t dbg_of(state_e s);
    dbg_t d;
    d.state  = s;
    d.halted = (s == ST_HALT) || (s == ST_BRK);
    d.bp_hit = (s == ST_BRK);
    return d;
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Front-panel / core side signals of the step controller.
interface cpu_step_ctrl_if #(parameter int CYC_W = 16);
  logic             Turbo;
  logic             Run_btn;
  logic             Halt_btn;
  logic             Step_btn;
  logic             Bp_en;
  logic [7:0]       Bp_addr;
  logic [7:0]       IP;
  logic             Go;
  logic             Halted;
  logic             Bp_hit;
  logic [1:0]       State;
  logic [CYC_W-1:0] Cycles;

  modport master (output Turbo, Run_btn, Halt_btn, Step_btn, Bp_en, Bp_addr, IP,
                  input  Go, Halted, Bp_hit, State, Cycles);
  modport slave  (input  Turbo, Run_btn, Halt_btn, Step_btn, Bp_en, Bp_addr, IP,
                  output Go, Halted, Bp_hit, State, Cycles);
endinterface

// File: rtl/cpu_step_ctrl_sync_edge.sv
// 2-FF synchroniser plus edge register: synced level and one-cycle rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic lvl,
  output logic rise
);
  logic [2:0] sh_q, sh_d;

  always_comb sh_d = {sh_q[1:0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_q <= '0;
    else        sh_q <= sh_d;
  end

  assign lvl  = sh_q[1];
  assign rise = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/cpu_step_ctrl.sv
// Execution sequencer: issues the single-cycle Go that qualifies every IP update,
// with free-run (divided/turbo), halt, single-step and breakpoint control.
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int DIV_W     = 4,
  parameter bit START_RUN = 1'b1,
  parameter int CYC_W     = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  cpu_step_ctrl_if.slave  bus
);
  logic       turbo_s, run_e, halt_e, step_e;
  logic       turbo_rise_unused;
  logic [2:0] btn_lvl_unused;

  sync_edge u_turbo (.clk(Clock), .rst_n(Reset), .d(bus.Turbo),    .lvl(turbo_s),           .rise(turbo_rise_unused));
  sync_edge u_run   (.clk(Clock), .rst_n(Reset), .d(bus.Run_btn),  .lvl(btn_lvl_unused[0]), .rise(run_e));
  sync_edge u_halt  (.clk(Clock), .rst_n(Reset), .d(bus.Halt_btn), .lvl(btn_lvl_unused[1]), .rise(halt_e));
  sync_edge u_step  (.clk(Clock), .rst_n(Reset), .d(bus.Step_btn), .lvl(btn_lvl_unused[2]), .rise(step_e));

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CYC_W-1:0]   cycles_q, cycles_d;
  logic               skip_q, skip_d;
  logic               fire, bp_block, go_raw;

  always_comb begin
    fire     = (div_q == '0) | turbo_s;
    bp_block = bus.Bp_en & (bus.IP == bus.Bp_addr) & ~skip_q;
    go_raw   = 1'b0;
    state_d  = state_q;
    skip_d   = skip_q;
    case (state_q)
      ST_RUN: begin
        go_raw = fire & ~halt_e & ~bp_block;
        if (fire & bp_block) state_d = ST_BRK;
      end
      ST_STEP: begin
        go_raw  = 1'b1;
        state_d = ST_HALT;
      end
      default: begin
        if (run_e) begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
        end else if (step_e) begin
          state_d = ST_STEP;
        end
      end
    endcase
    // Halt outranks everything, but a committed STEP Go still goes out.
    if (halt_e) begin
      state_d = ST_HALT;
      skip_d  = skip_q;
    end
    if (go_raw) skip_d = 1'b0;
    cycles_d = cycles_q + CYC_W'(go_raw & ~(&cycles_q));
    div_d    = div_q + DIV_W'(1);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= START_RUN ? ST_RUN : ST_HALT;
      div_q    <= '0;
      cycles_q <= '0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cycles_q <= cycles_d;
      skip_q   <= skip_d;
    end
  end

  dbg_t dbg;
  assign dbg        = dbg_of(state_q);
  // Go is killed the instant reset asserts, even mid-cycle.
  assign bus.Go     = go_raw & Reset;
  assign bus.State  = dbg.state;
  assign bus.Halted = dbg.halted;
  assign bus.Bp_hit = dbg.bp_hit;
  assign bus.Cycles = cycles_q;
endmodule
